// File: rtl/text_console.sv
// text_console: byte-stream writer for the 80x25 text-mode frame buffer.
// Define TEXT_CONSOLE_TAB_EN to treat 0x09 as a tab stop instead of a glyph.
module text_console #(
    parameter logic [16:0] BASE         = 17'h0F000,
    parameter int          COLS         = 80,
    parameter int          ROWS         = 25,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attr_in,
    output logic [16:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] cursor,
    output logic        busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_PUT_CHAR  = 4'd1;
    localparam logic [3:0] S_PUT_ATTR  = 4'd2;
    localparam logic [3:0] S_SCR_RD    = 4'd3;
    localparam logic [3:0] S_SCR_WR    = 4'd4;
    localparam logic [3:0] S_FILL_CHAR = 4'd5;
    localparam logic [3:0] S_FILL_ATTR = 4'd6;
    localparam logic [3:0] S_CLR_CHAR  = 4'd7;
    localparam logic [3:0] S_CLR_ATTR  = 4'd8;

    localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);
    localparam logic [6:0]  COL_LAST   = 7'(COLS - 1);
    localparam logic [11:0] CELL_LAST  = 12'(COLS * ROWS - 1);
    localparam logic [11:0] FILL_FIRST = 12'(COLS * (ROWS - 1));
    localparam logic [11:0] K_LAST     = 12'(2 * COLS * (ROWS - 1) - 1);
    localparam logic [16:0] ROW_BYTES  = 17'(2 * COLS);

    logic [3:0]  state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [6:0]  pcol_q, pcol_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic [11:0] idx_q, idx_d;
    logic        do_nl;

    logic [16:0] cell_addr;
    logic [16:0] idx_addr;

    assign cursor    = 11'(row_q) * 11'(COLS) + 11'(col_q);
    assign cell_addr = BASE + {5'd0, cursor, 1'b0};
    assign idx_addr  = BASE + {4'd0, idx_q, 1'b0};
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pcol_d  = pcol_q;
        char_d  = char_q;
        attr_d  = attr_q;
        idx_d   = idx_q;
        do_nl   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    char_d = in_data;
                    attr_d = attr_in;
                    case (in_data)
                        8'h0D: col_d = 7'd0;
                        8'h0A: begin
                            if (row_q == ROW_LAST) begin
                                pcol_d  = col_q;
                                idx_d   = 12'd0;
                                state_d = S_SCR_RD;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end
                        8'h08: begin
                            if (col_q != 7'd0) col_d = col_q - 7'd1;
                        end
                        8'h0C: begin
                            idx_d   = 12'd0;
                            state_d = S_CLR_CHAR;
                        end
`ifdef TEXT_CONSOLE_TAB_EN
                        8'h09: begin
                            if (col_q >= 7'(COLS - 8)) do_nl = 1'b1;
                            else col_d = (col_q | 7'd7) + 7'd1;
                        end
`endif
                        default: state_d = S_PUT_CHAR;
                    endcase
                end
            end
            S_PUT_CHAR: state_d = S_PUT_ATTR;
            S_PUT_ATTR: begin
                if (col_q == COL_LAST) begin
                    do_nl = 1'b1;
                end else begin
                    col_d   = col_q + 7'd1;
                    state_d = S_IDLE;
                end
            end
            S_SCR_RD: state_d = S_SCR_WR;
            S_SCR_WR: begin
                if (idx_q == K_LAST) begin
                    idx_d   = FILL_FIRST;
                    state_d = S_FILL_CHAR;
                end else begin
                    idx_d   = idx_q + 12'd1;
                    state_d = S_SCR_RD;
                end
            end
            S_FILL_CHAR: state_d = S_FILL_ATTR;
            S_FILL_ATTR: begin
                if (idx_q == CELL_LAST) begin
                    row_d   = ROW_LAST;
                    col_d   = pcol_q;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 12'd1;
                    state_d = S_FILL_CHAR;
                end
            end
            S_CLR_CHAR: state_d = S_CLR_ATTR;
            S_CLR_ATTR: begin
                if (idx_q == CELL_LAST) begin
                    row_d   = 5'd0;
                    col_d   = 7'd0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 12'd1;
                    state_d = S_CLR_CHAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line advance; the bottom row keeps the visible cursor until the scroll ends
        if (do_nl) begin
            if (row_q == ROW_LAST) begin
                pcol_d  = 7'd0;
                idx_d   = 12'd0;
                state_d = S_SCR_RD;
            end else begin
                row_d   = row_q + 5'd1;
                col_d   = 7'd0;
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_address = 17'd0;
        mem_wdata   = 8'd0;
        unique case (state_q)
            S_PUT_CHAR: begin
                mem_we      = 1'b1;
                mem_address = cell_addr;
                mem_wdata   = char_q;
            end
            S_PUT_ATTR: begin
                mem_we      = 1'b1;
                mem_address = cell_addr + 17'd1;
                mem_wdata   = attr_q;
            end
            S_SCR_RD: begin
                mem_address = BASE + ROW_BYTES + {5'd0, idx_q};
            end
            S_SCR_WR: begin
                mem_we      = 1'b1;
                mem_address = BASE + {5'd0, idx_q};
                mem_wdata   = mem_rdata;
            end
            S_FILL_CHAR, S_CLR_CHAR: begin
                mem_we      = 1'b1;
                mem_address = idx_addr;
                mem_wdata   = 8'h20;
            end
            S_FILL_ATTR, S_CLR_ATTR: begin
                mem_we      = 1'b1;
                mem_address = idx_addr + 17'd1;
                mem_wdata   = attr_q;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            pcol_q  <= 7'd0;
            char_q  <= 8'd0;
            attr_q  <= DEFAULT_ATTR;
            idx_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pcol_q  <= pcol_d;
            char_q  <= char_d;
            attr_q  <= attr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: behavioural screen model plus synchronous RAM.
// Randomized byte streams are checked against the model cell by cell.
module tb_text_console;

    localparam int BASE = 'h0F000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  attr_in = 8'd0;
    logic [16:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = 8'd0;
    logic [10:0] cursor;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int oob = 0;

    logic [7:0] vram [0:131071];
    logic [7:0] scr [0:3999];
    int         exp_cur = 0;

    text_console dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .attr_in(attr_in),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cursor(cursor), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) begin
            vram[mem_address] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        mem_rdata <= vram[mem_address];
    end

    always @(negedge clock) begin
        if (cursor > 11'd1999) oob <= oob + 1;
    end

    function automatic int screen_diff();
        int n = 0;
        for (int i = 0; i < 4000; i++)
            if (vram[BASE + i] !== scr[i]) n++;
        return n;
    endfunction

    task automatic model_scroll(input logic [7:0] a);
        for (int k = 0; k < 3840; k++) scr[k] = scr[k + 160];
        for (int i = 3840; i < 4000; i++) scr[i] = (i % 2 == 0) ? 8'h20 : a;
    endtask

    // Screen rules in plain row/column arithmetic; eb is the expected busy length
    task automatic model_byte(input logic [7:0] b, input logic [7:0] a,
                              output int eb);
        int r, c, nc;
        r = exp_cur / 80;
        c = exp_cur % 80;
        eb = 0;
        case (b)
            8'h0D: exp_cur = r * 80;
            8'h0A: begin
                if (r < 24) exp_cur += 80;
                else begin model_scroll(a); eb = 7840; end
            end
            8'h08: if (c > 0) exp_cur -= 1;
            8'h0C: begin
                for (int i = 0; i < 4000; i++)
                    scr[i] = (i % 2 == 0) ? 8'h20 : a;
                exp_cur = 0;
                eb = 4000;
            end
`ifdef TEXT_CONSOLE_TAB_EN
            8'h09: begin
                nc = (c / 8 + 1) * 8;
                if (nc < 80) exp_cur = r * 80 + nc;
                else if (r < 24) exp_cur = (r + 1) * 80;
                else begin model_scroll(a); exp_cur = 1920; eb = 7840; end
            end
`endif
            default: begin
                scr[2 * exp_cur] = b;
                scr[2 * exp_cur + 1] = a;
                exp_cur += 1;
                eb = 2;
                if (exp_cur == 2000) begin
                    model_scroll(a);
                    exp_cur = 1920;
                    eb = 7842;
                end
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] a,
                             output int nbusy);
        int w;
        w = 0;
        nbusy = 0;
        while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
        end
        in_data = b;
        attr_in = a;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            if (!busy) break;
            nbusy++;
        end
        if (busy) begin
            checks++; failures++;
            $display("FAIL busy_timeout: busy=%0b required 0", busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_cur = 0;
        @(negedge clock);
    endtask

    task automatic drive(input logic [7:0] b, input logic [7:0] a);
        int nb, eb;
        send_byte(b, a, nb);
        model_byte(b, a, eb);
    endtask

    task automatic test_reset();
        int eb;
        do_reset();
        checks++;
        if ({cursor, in_ready, busy, mem_we, mem_address} !==
            {11'd0, 1'b1, 1'b0, 1'b0, 17'd0}) begin
            failures++;
            $display("FAIL reset_state: cur=%0d rdy=%0b busy=%0b we=%0b addr=%h required 0 1 0 0 0",
                     cursor, in_ready, busy, mem_we, mem_address);
        end
        in_data = 8'h41;
        attr_in = 8'h1F;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({mem_we, mem_address, mem_wdata, in_ready} !== {1'b1, 17'h0F000, 8'h41, 1'b0}) begin
            failures++;
            $display("FAIL put_char: we=%0b addr=%h data=%h rdy=%0b required 1 0f000 41 0",
                     mem_we, mem_address, mem_wdata, in_ready);
        end
        @(negedge clock);
        checks++;
        if ({mem_we, mem_address, mem_wdata, in_ready} !== {1'b1, 17'h0F001, 8'h1F, 1'b0}) begin
            failures++;
            $display("FAIL put_attr: we=%0b addr=%h data=%h rdy=%0b required 1 0f001 1f 0",
                     mem_we, mem_address, mem_wdata, in_ready);
        end
        @(negedge clock);
        checks++;
        if ({in_ready, mem_we, cursor} !== {1'b1, 1'b0, 11'd1}) begin
            failures++;
            $display("FAIL put_done: rdy=%0b we=%0b cur=%0d required 1 0 1",
                     in_ready, mem_we, cursor);
        end
        model_byte(8'h41, 8'h1F, eb);
    endtask

    task automatic test_ctrl_codes();
        logic [7:0] seq [9] = '{8'h42, 8'h42, 8'h42, 8'h42, 8'h42,
                                8'h08, 8'h0D, 8'h0A, 8'h08};
        int         cur [9] = '{1, 2, 3, 4, 5, 4, 0, 80, 80};
        int nb, eb, w0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            w0 = wr_count;
            send_byte(seq[i], 8'h07, nb);
            model_byte(seq[i], 8'h07, eb);
            checks++;
            if (cursor !== 11'(cur[i])) begin
                failures++;
                $display("FAIL ctrl_cursor[%0d]: cur=%0d required %0d", i, cursor, cur[i]);
            end
            if (i >= 5) begin
                checks++;
                if (wr_count - w0 != 0 || nb != 0) begin
                    failures++;
                    $display("FAIL ctrl_nowrite[%0d]: writes=%0d busy=%0d required 0 0",
                             i, wr_count - w0, nb);
                end
            end
        end
    endtask

    task automatic test_scroll();
        int nb, eb, bad;
        logic [7:0] ch;
        do_reset();
        vram[BASE + 160] = 8'h55;
        scr[160] = 8'h55;
        for (int i = 0; i < 24; i++) drive(8'h0A, 8'h07);
        for (int i = 0; i < 79; i++) begin
            ch = 8'($urandom_range(8'h20, 8'h7E));
            drive(ch, 8'($urandom));
        end
        checks++;
        if (cursor !== 11'd1999) begin
            failures++;
            $display("FAIL scroll_pre: cur=%0d required 1999", cursor);
        end
        send_byte(8'h43, 8'h2E, nb);
        model_byte(8'h43, 8'h2E, eb);
        checks++;
        if (nb != 7842 || cursor !== 11'd1920) begin
            failures++;
            $display("FAIL scroll_done: busy=%0d cur=%0d required 7842 1920", nb, cursor);
        end
        checks++;
        if (vram[BASE] !== 8'h55) begin
            failures++;
            $display("FAIL scroll_copy: f000=%h required 55", vram[BASE]);
        end
        bad = 0;
        for (int i = 3840; i < 4000; i++)
            if (vram[BASE + i] !== ((i % 2 == 0) ? 8'h20 : 8'h2E)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL scroll_fill: bad=%0d required 0", bad);
        end
        checks++;
        if (screen_diff() != 0) begin
            failures++;
            $display("FAIL scroll_screen: diff=%0d required 0", screen_diff());
        end
    endtask

    task automatic test_abort();
        int nb, eb, found;
        do_reset();
        for (int i = 0; i < 24; i++) drive(8'h0A, 8'h07);
        in_data = 8'h0A;
        attr_in = 8'h07;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (busy && !mem_we && mem_address == 17'(BASE + 260)) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) begin
            failures++;
            $display("FAIL abort_reach: found=%0d required 1", found);
        end
        do_reset();
        checks++;
        if ({busy, in_ready, mem_we, cursor} !== {1'b0, 1'b1, 1'b0, 11'd0}) begin
            failures++;
            $display("FAIL abort_state: busy=%0b rdy=%0b we=%0b cur=%0d required 0 1 0 0",
                     busy, in_ready, mem_we, cursor);
        end
        send_byte(8'h41, 8'h07, nb);
        model_byte(8'h41, 8'h07, eb);
        checks++;
        if ({vram[BASE], vram[BASE + 1], cursor} !== {8'h41, 8'h07, 11'd1}) begin
            failures++;
            $display("FAIL abort_print: f000=%h f001=%h cur=%0d required 41 07 1",
                     vram[BASE], vram[BASE + 1], cursor);
        end
    endtask

    task automatic test_clear();
        int nb, eb, w0, bad;
        w0 = wr_count;
        send_byte(8'h0C, 8'h70, nb);
        model_byte(8'h0C, 8'h70, eb);
        checks++;
        if (nb != 4000 || wr_count - w0 != 4000 || cursor !== 11'd0) begin
            failures++;
            $display("FAIL clear_len: busy=%0d writes=%0d cur=%0d required 4000 4000 0",
                     nb, wr_count - w0, cursor);
        end
        bad = 0;
        for (int i = 0; i < 4000; i++)
            if (vram[BASE + i] !== ((i % 2 == 0) ? 8'h20 : 8'h70)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clear_fill: bad=%0d required 0", bad);
        end
    endtask

    task automatic test_tab();
        int nb, eb;
        do_reset();
`ifdef TEXT_CONSOLE_TAB_EN
        for (int i = 0; i < 3; i++) drive(8'h61, 8'h07);
        send_byte(8'h09, 8'h07, nb);
        model_byte(8'h09, 8'h07, eb);
        checks++;
        if (cursor !== 11'd8 || nb != 0) begin
            failures++;
            $display("FAIL tab_col3: cur=%0d busy=%0d required 8 0", cursor, nb);
        end
        for (int i = 0; i < 24; i++) drive(8'h0A, 8'h07);
        for (int i = 0; i < 67; i++) drive(8'h62, 8'h1E);
        send_byte(8'h09, 8'h4A, nb);
        model_byte(8'h09, 8'h4A, eb);
        checks++;
        if (cursor !== 11'd1920 || nb != 7840) begin
            failures++;
            $display("FAIL tab_scroll: cur=%0d busy=%0d required 1920 7840", cursor, nb);
        end
        checks++;
        if (screen_diff() != 0) begin
            failures++;
            $display("FAIL tab_screen: diff=%0d required 0", screen_diff());
        end
`else
        for (int i = 0; i < 5; i++) drive(8'h61, 8'h07);
        send_byte(8'h09, 8'h3C, nb);
        model_byte(8'h09, 8'h3C, eb);
        checks++;
        if ({vram[BASE + 10], vram[BASE + 11], cursor} !== {8'h09, 8'h3C, 11'd6}) begin
            failures++;
            $display("FAIL tab_glyph: ch=%h at=%h cur=%0d required 09 3c 6",
                     vram[BASE + 10], vram[BASE + 11], cursor);
        end
`endif
    endtask

    task automatic test_random();
        int nb, eb, r;
        logic [7:0] b, a;
        do_reset();
        for (int i = 0; i < 22; i++) drive(8'h0A, 8'h07);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) b = 8'h0A;
            else if (r < 12) b = 8'h0D;
            else if (r < 16) b = 8'h08;
            else if (r < 20) b = 8'h09;
            else b = 8'($urandom_range(8'h20, 8'h7E));
            a = 8'($urandom);
            send_byte(b, a, nb);
            model_byte(b, a, eb);
            checks++;
            if (cursor !== 11'(exp_cur) || nb != eb) begin
                failures++;
                $display("FAIL rand[%0d] byte %h: cur=%0d busy=%0d required %0d %0d",
                         i, b, cursor, nb, exp_cur, eb);
            end
        end
        checks++;
        if (screen_diff() != 0) begin
            failures++;
            $display("FAIL rand_screen: diff=%0d required 0", screen_diff());
        end
        checks++;
        if (oob != 0) begin
            failures++;
            $display("FAIL cursor_range: out_of_range=%0d required 0", oob);
        end
    endtask

    initial begin
        for (int i = 0; i < 4000; i++) begin
            vram[BASE + i] = 8'($urandom);
            scr[i] = vram[BASE + i];
        end
        test_reset();
        test_ctrl_codes();
        test_scroll();
        test_abort();
        test_clear();
        test_tab();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: time=%0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
